// File: rtl/tag_issue_ctrl_if.sv
// Handshake bundle between the column tag allocator controller and its host.
// start is accepted only while ready is high; flush and tile_done are one-cycle strobes.
interface tag_issue_ctrl_if #(
    parameter int NUM_COL = 8
);
    localparam int TAG_W = $clog2(NUM_COL) + 1;

    logic               start;
    logic               abort;
    logic [NUM_COL-1:0] col_done;
    logic [TAG_W-1:0]   tag_in;
    logic               flush;
    logic [NUM_COL-1:0] tag_locks;
    logic               ready;
    logic               busy;
    logic               tile_done;
    logic [2:0]         state_dbg;

    modport master (
        output start, abort, col_done,
        input  tag_in, flush, tag_locks, ready, busy, tile_done, state_dbg
    );

    modport slave (
        input  start, abort, col_done,
        output tag_in, flush, tag_locks, ready, busy, tile_done, state_dbg
    );
endinterface

// File: rtl/tag_issue_ctrl.sv
// Tile-level tag issuer: hands out a non-zero tag, walks a thermometer lock mask
// across the columns, waits for every column to finish, then releases the locks.
module tag_issue_ctrl #(
    parameter int NUM_COL = 8
) (
    input  logic                clk,
    input  logic                rstn,
    tag_issue_ctrl_if.slave     bus
);
    localparam int TAG_W  = $clog2(NUM_COL) + 1;
    localparam int STEP_W = $clog2(NUM_COL);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_COL - 2);
    localparam logic [TAG_W-1:0]  MAX_TAG   = TAG_W'(NUM_COL);
    localparam logic [TAG_W-1:0]  TAG_ONE   = TAG_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SHIFT   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [NUM_COL-1:0] locks_q, locks_d;
    logic [NUM_COL-1:0] done_q, done_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               flush_q, flush_d;
    logic               tile_done_q, tile_done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            locks_q     <= '0;
            done_q      <= '0;
            step_q      <= '0;
            flush_q     <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            locks_q     <= locks_d;
            done_q      <= done_d;
            step_q      <= step_d;
            flush_q     <= flush_d;
            tile_done_q <= tile_done_d;
        end
    end

    // Registered outputs are computed from the next state so they line up
    // with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        locks_d     = locks_q;
        done_d      = done_q;
        step_d      = step_q;
        flush_d     = 1'b0;
        tile_done_d = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
            locks_d = '0;
            done_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    locks_d = '0;
                    done_d  = '0;
                    if (bus.start) begin
                        cnt_d   = (cnt_q == MAX_TAG) ? TAG_ONE : cnt_q + TAG_ONE;
                        tag_d   = cnt_d;
                        step_d  = '0;
                        flush_d = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    locks_d = NUM_COL'(1);
                    done_d  = '0;
                    step_d  = '0;
                    state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    done_d  = done_q | bus.col_done;
                    locks_d = {locks_q[NUM_COL-2:0], 1'b1};
                    step_d  = step_q + STEP_W'(1);
                    if (step_q == LAST_STEP) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    done_d = done_q | bus.col_done;
                    // Only the mask as registered counts, so WAIT lasts at least one cycle.
                    if (&done_q) begin
                        locks_d     = '0;
                        done_d      = '0;
                        tile_done_d = 1'b1;
                        state_d     = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    locks_d = '0;
                    done_d  = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    locks_d = '0;
                    done_d  = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.tag_in    = tag_q;
    assign bus.flush     = flush_q;
    assign bus.tag_locks = locks_q;
    assign bus.tile_done = tile_done_q;
    assign bus.ready     = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;

    a_flush_in_issue : assert property (@(posedge clk) disable iff (!rstn)
        flush_q == (state_q == S_ISSUE));
    a_done_in_release : assert property (@(posedge clk) disable iff (!rstn)
        tile_done_q == (state_q == S_RELEASE));
    a_tag_nonzero : assert property (@(posedge clk) disable iff (!rstn)
        flush_q |-> (tag_q != '0));
endmodule
